// File: rtl/branch_target_predictor.sv
// Next-PC generator: direct-mapped BTB with 2-bit direction counters, trained by EX.
// Lookup is combinational on pc_i; training and statistics update on the rising edge.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      pc_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [31:0]      upd_target_i,
    input  logic             upd_mispredict_i,
    output logic [31:0]      next_pc_o,
    output logic             pred_taken_o,
    output logic [31:0]      pred_target_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);
    localparam int TAG_W = 32 - INDEX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [CNT_W-1:0]   branch_cnt_q;
    logic [CNT_W-1:0]   mispredict_cnt_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic [INDEX_W-1:0] uidx;
    logic [TAG_W-1:0]   utag;
    logic               uhit;
    logic               unused_pc_low;

    // Byte offset within the instruction word plays no part in lookup or training.
    assign unused_pc_low = ^{pc_i[1:0], upd_pc_i[1:0]};

    assign idx  = pc_i[INDEX_W+1:2];
    assign tag  = pc_i[31:INDEX_W+2];
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign uidx = upd_pc_i[INDEX_W+1:2];
    assign utag = upd_pc_i[31:INDEX_W+2];
    assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

    // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
    always_comb begin
        pred_taken_o  = hit && ctr_q[idx][1];
        pred_target_o = hit ? target_q[idx] : 32'd0;
        if (redirect_i) begin
            next_pc_o = redirect_pc_i;
        end else if (pred_taken_o) begin
            next_pc_o = target_q[idx];
        end else begin
            next_pc_o = pc_i + 32'd4;
        end
    end

    // upd_valid_i is a single-cycle strobe with no back-pressure: every presented
    // resolution is accepted on the edge where it is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q          <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_valid_i) begin
            if (uhit) begin
                if (upd_taken_i) begin
                    target_q[uidx] <= upd_target_i;
                    if (ctr_q[uidx] != 2'b11) ctr_q[uidx] <= ctr_q[uidx] + 2'b01;
                end else begin
                    if (ctr_q[uidx] != 2'b00) ctr_q[uidx] <= ctr_q[uidx] - 2'b01;
                end
            end else if (upd_taken_i) begin
                valid_q[uidx]  <= 1'b1;
                tag_q[uidx]    <= utag;
                target_q[uidx] <= upd_target_i;
                ctr_q[uidx]    <= 2'b10;
            end
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (upd_mispredict_i && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
            end
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: expected outputs queued by the driver,
// popped and compared by a monitor on the falling edge.
module tb_branch_target_predictor;
    localparam int EW = 32 + 1 + 32 + 16 + 16 + 4 + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mis = 1'b0;

    logic [31:0] next_pc, pred_target, next_pc4, pred_target4;
    logic        pred_taken, pred_taken4;
    logic [15:0] branch_cnt, mis_cnt;
    logic [3:0]  branch_cnt4, mis_cnt4;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            total = 0;
    int            bad = 0;
    logic          chk = 1'b0;

    always #5 clk = ~clk;

    branch_target_predictor #(.ENTRIES(16), .INDEX_W(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_mispredict_i(upd_mis),
        .next_pc_o(next_pc), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
        .branch_cnt_o(branch_cnt), .mispredict_cnt_o(mis_cnt)
    );

    branch_target_predictor #(.ENTRIES(16), .INDEX_W(4), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_mispredict_i(upd_mis),
        .next_pc_o(next_pc4), .pred_taken_o(pred_taken4), .pred_target_o(pred_target4),
        .branch_cnt_o(branch_cnt4), .mispredict_cnt_o(mis_cnt4)
    );

    task automatic drive(input logic [31:0] p, input logic rd, input logic [31:0] rpc,
                         input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic um);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pc = p;
        redirect = rd;
        redirect_pc = rpc;
        upd_valid = uv;
        upd_pc = upc;
        upd_taken = ut;
        upd_target = utgt;
        upd_mis = um;
        chk = 1'b0;
    endtask

    task automatic idle(input logic [31:0] p);
        drive(p, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic um);
        drive(p, 1'b0, 32'd0, 1'b1, upc, ut, utgt, um);
    endtask

    task automatic reset_cycle(input logic with_upd);
        drive(32'h80, 1'b0, 32'd0, with_upd, 32'h80, 1'b1, 32'h500, 1'b1);
        rst = 1'b1;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] nxt, input logic pt,
                              input logic [31:0] tgt, input int bc, input int mc);
        logic [15:0] b16, m16;
        logic [3:0]  b4, m4;
        b16 = bc[15:0];
        m16 = mc[15:0];
        b4 = (bc > 15) ? 4'hf : b16[3:0];
        m4 = (mc > 15) ? 4'hf : m16[3:0];
        exp_q.push_back({nxt, pt, tgt, b16, m16, b4, m4});
        name_q.push_back(nm);
        chk = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk) begin
            logic [EW-1:0] act, e;
            string nm;
            act = {next_pc, pred_taken, pred_target, branch_cnt, mis_cnt, branch_cnt4, mis_cnt4};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL monitor: output presented with no expected entry, actual=%h", act);
            end else begin
                e = exp_q.pop_front();
                nm = name_q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: actual {nxt,pt,tgt,bc,mc,bc4,mc4}=%h expected=%h", nm, act, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_cycle(1'b0);
        idle(32'h40);                          expect_out("reset_lookup", 32'h44, 0, 32'h0, 0, 0);
        upd(32'h40, 32'h40, 1, 32'h100, 1);    expect_out("same_cycle_alloc", 32'h44, 0, 32'h0, 0, 0);
        idle(32'h40);                          expect_out("alloc_taken", 32'h100, 1, 32'h100, 1, 1);
        upd(32'h40, 32'h40, 0, 32'h0, 1);      expect_out("nt1_pre", 32'h100, 1, 32'h100, 1, 1);
        upd(32'h40, 32'h40, 0, 32'h0, 0);      expect_out("ctr1", 32'h44, 0, 32'h100, 2, 2);
        idle(32'h40);                          expect_out("ctr0", 32'h44, 0, 32'h100, 3, 2);
        upd(32'h40, 32'h40, 0, 32'h0, 0);      expect_out("sat0_a", 32'h44, 0, 32'h100, 3, 2);
        upd(32'h40, 32'h40, 0, 32'h0, 0);      expect_out("sat0_b", 32'h44, 0, 32'h100, 4, 2);
        upd(32'h40, 32'h40, 0, 32'h0, 0);      expect_out("sat0_c", 32'h44, 0, 32'h100, 5, 2);
        idle(32'h40);                          expect_out("sat0_d", 32'h44, 0, 32'h100, 6, 2);
        upd(32'h40, 32'h40, 1, 32'h100, 1);    expect_out("up_from0", 32'h44, 0, 32'h100, 6, 2);
        idle(32'h40);                          expect_out("ctr1_again", 32'h44, 0, 32'h100, 7, 3);
        upd(32'h40, 32'h40, 1, 32'h100, 1);    expect_out("same_cycle_nobypass", 32'h44, 0, 32'h100, 7, 3);
        idle(32'h40);                          expect_out("same_cycle_next", 32'h100, 1, 32'h100, 8, 4);
        upd(32'h40, 32'h40, 1, 32'h100, 0);    expect_out("up_to3_a", 32'h100, 1, 32'h100, 8, 4);
        upd(32'h40, 32'h40, 1, 32'h100, 0);    expect_out("up_to3_b", 32'h100, 1, 32'h100, 9, 4);
        upd(32'h40, 32'h40, 0, 32'h0, 1);      expect_out("sat3_dn", 32'h100, 1, 32'h100, 10, 4);
        idle(32'h40);                          expect_out("sat3_ctr2", 32'h100, 1, 32'h100, 11, 5);
        upd(32'h40, 32'h40, 0, 32'h0, 1);      expect_out("dn_to1_pre", 32'h100, 1, 32'h100, 11, 5);
        idle(32'h40);                          expect_out("dn_to1", 32'h44, 0, 32'h100, 12, 6);
        upd(32'h40, 32'h40, 1, 32'h100, 0);    expect_out("retrain", 32'h44, 0, 32'h100, 12, 6);
        upd(32'h40, 32'h80, 1, 32'h200, 1);    expect_out("alias_pre", 32'h100, 1, 32'h100, 13, 6);
        idle(32'h40);                          expect_out("alias_evicted", 32'h44, 0, 32'h0, 14, 7);
        idle(32'h80);                          expect_out("alias_new", 32'h200, 1, 32'h200, 14, 7);
        upd(32'h80, 32'h80, 1, 32'h240, 1);    expect_out("tgt_upd_pre", 32'h200, 1, 32'h200, 14, 7);
        idle(32'h80);                          expect_out("tgt_upd", 32'h240, 1, 32'h240, 15, 8);
        drive(32'h80, 1, 32'h300, 0, 32'h0, 0, 32'h0, 0);
        expect_out("redirect", 32'h300, 1, 32'h240, 15, 8);
        drive(32'h80, 0, 32'h0, 0, 32'h80, 1, 32'h700, 1);
        expect_out("mis_no_valid", 32'h240, 1, 32'h240, 15, 8);
        idle(32'hFFFF_FFFC);                   expect_out("wrap", 32'h0, 0, 32'h0, 15, 8);
        upd(32'h44, 32'h44, 0, 32'h0, 0);      expect_out("nt_miss_pre", 32'h48, 0, 32'h0, 15, 8);
        idle(32'h44);                          expect_out("nt_miss_noalloc", 32'h48, 0, 32'h0, 16, 8);
        reset_cycle(1'b1);
        idle(32'h80);                          expect_out("reset_with_upd", 32'h84, 0, 32'h0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            upd(32'h44, 32'h44, 1'b0, 32'h0, (i < 17) ? 1'b1 : 1'b0);
        end
        idle(32'h44);                          expect_out("counters_20_17", 32'h48, 0, 32'h0, 20, 17);
        idle(32'h0);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Next-PC generator feeding the PC register's pc_i input.
- Holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Each cycle it looks up the current fetch PC and produces the predicted next PC (BTB target or PC+4).
- The EX stage trains it on branch resolution and redirects it on a mispredict.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of two.
- INDEX_W, 4, log2(ENTRIES); the index is pc[INDEX_W+1:2].
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- pc_i  input  32  current fetch PC (the PC register's pc_o).
- redirect_i  input  1  EX-stage mispredict redirect request.
- redirect_pc_i  input  32  correct PC when redirect_i=1.
- upd_valid_i  input  1  a resolved branch is presented this cycle.
- upd_pc_i  input  32  PC of the resolved branch.
- upd_taken_i  input  1  resolved direction.
- upd_target_i  input  32  resolved taken target.
- upd_mispredict_i  input  1  the prediction for this branch was wrong.
- next_pc_o  output  32  predicted next PC, to PC pc_i.
- pred_taken_o  output  1  prediction for pc_i; pipelined alongside the instruction.
- pred_target_o  output  32  BTB target for pc_i; 0 on a miss.
- branch_cnt_o  output  CNT_W  number of resolved branches.
- mispredict_cnt_o  output  CNT_W  number of mispredicts.

Behaviour:
- Storage per entry: valid (1), tag (32-INDEX_W-2 bits = pc[31:INDEX_W+2]), target (32), ctr (2).
- pc[1:0] is ignored everywhere.

Reset (rst_i=1 at a clock edge):
- All valid bits cleared, ctr=2'b01, target=0, tag=0.
- branch_cnt_o=0 and mispredict_cnt_o=0.
- Reset has priority over any update in the same cycle.
- A reset asserted mid-stream discards all training.

Lookup (combinational, zero latency):
- idx = pc_i[INDEX_W+1:2]; hit = valid[idx] && tag[idx]==pc_i[31:INDEX_W+2].
- pred_taken_o = hit && ctr[idx][1].
- pred_target_o = hit ? target[idx] : 0.

next_pc_o priority:
1. redirect_i=1 -> redirect_pc_i.
2. pred_taken_o=1 -> target[idx].
3. Otherwise -> pc_i+4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).

Hazard and reset interaction on the output side:
- next_pc_o does not depend on the hazard signal; the PC stage owns stall handling.
- During rst_i, next_pc_o still follows the rules above using post-reset table contents on the following cycle.

Update (registered, effective from the cycle after the edge; uidx from upd_pc_i):
- Hit entry:
  - taken -> ctr = min(ctr+1, 3), target = upd_target_i.
  - not taken -> ctr = max(ctr-1, 0); target unchanged.
- Miss, taken -> allocate or overwrite: valid=1, tag from upd_pc_i, target=upd_target_i, ctr=2'b10 (weakly taken).
- Miss, not taken -> no table change.

Simultaneous update and lookup, same index:
- The lookup sees the pre-update contents; there is no bypass.
- Next cycle sees the new contents.

Statistics:
- On upd_valid_i: branch_cnt_o += 1.
- On upd_valid_i && upd_mispredict_i: mispredict_cnt_o += 1.
- Both counters saturate at all-ones and do not wrap.
- upd_mispredict_i without upd_valid_i is ignored.

Test Plan:
- Reset, then pc_i=0x00000040 -> pred_taken_o=0, pred_target_o=0, next_pc_o=0x00000044, both counters 0.
- Update pc=0x40, taken, target 0x100 -> next cycle with pc_i=0x40: pred_taken_o=1, next_pc_o=0x100, ctr=2.
  - Two not-taken updates -> ctr=0, next_pc_o=0x44.
  - Three more not-taken updates -> ctr stays 0.
- Alias test: train pc=0x40 taken -> 0x100, then update pc=0x80 (same index, different tag) taken -> 0x200.
  - pc_i=0x40 -> miss, next_pc_o=0x44.
  - pc_i=0x80 -> next_pc_o=0x200.
- redirect_i=1 with redirect_pc_i=0x300 while pc_i hits taken -> next_pc_o=0x300.
  - pc_i=0xFFFFFFFC with no hit -> next_pc_o=0x00000000.
- Same-cycle update and lookup at pc 0x40, trained entry ctr=1 updated taken -> that cycle pred_taken_o=0, next cycle 1.
  - rst_i together with upd_valid_i -> entry invalid and counters 0 afterward.
- Counter test, CNT_W=4 build: 20 updates with 17 mispredicts -> branch_cnt_o=15 and mispredict_cnt_o=15 (both saturated).
